// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder: default widths, FSM state
// encoding and the saturation limit used by the access counters.
package mem_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 4;
  localparam int unsigned CNT_W      = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = 8'hFF;

  // INIT fills the array with the init value; RUN serves accesses.
  typedef enum logic [0:0] {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/mem_responder_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at MAX instead of wrapping.
module sat_counter
  import mem_pkg::*;
#(
  parameter int unsigned      W   = CNT_W,
  parameter logic [W-1:0]     MAX = CNT_MAX
) (
  input  logic         i_clk,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  // Count qualified increments, clear has priority, stop once MAX is reached.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != MAX)) begin
      r_count <= r_count + 1'b1;
    end else begin
      r_count <= r_count;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/mem_responder.sv
// Single-port memory responder: after reset the whole array is filled with
// INIT_VAL (one word per cycle), then reads/writes are served every cycle
// with registered read data. Accesses during fill are dropped and flagged.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned        DATA_W      = DATA_W_DEF,
  parameter int unsigned        ADDR_W      = ADDR_W_DEF,
  parameter logic [DATA_W-1:0]  INIT_VAL    = 16'h0000,
  parameter bit                 WRITE_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              init_busy,
  output logic              acc_drop,
  output logic [CNT_W-1:0]  wr_count,
  output logic [CNT_W-1:0]  rd_count
);

  localparam int unsigned       DEPTH    = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [DATA_W-1:0]   r_douta;
  logic                r_acc_drop;

  logic                w_in_init;
  logic                w_rd;
  logic                w_wr;
  logic                w_drop;
  logic                w_mem_we;
  logic [ADDR_W-1:0]   w_mem_addr;
  logic [DATA_W-1:0]   w_mem_din;
  logic [DATA_W-1:0]   w_rd_data;

  // Next-state logic: leave INIT right after the last word has been filled.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT: begin
        if (r_ptr == PTR_LAST) begin
          w_state_nxt = RUN;
        end else begin
          w_state_nxt = INIT;
        end
      end
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  // Access decode and the single write port mux (fill pointer vs. user write).
  always_comb begin
    w_in_init  = (r_state == INIT);
    w_rd       = 1'b0;
    w_wr       = 1'b0;
    w_drop     = 1'b0;
    w_mem_we   = 1'b0;
    w_mem_addr = r_ptr;
    w_mem_din  = INIT_VAL;
    w_rd_data  = r_mem[addra];
    if (rst) begin
      w_mem_we = 1'b0;
    end else if (w_in_init) begin
      w_mem_we = 1'b1;
      w_drop   = ena;
    end else if (ena) begin
      w_rd       = ~wea;
      w_wr       = wea;
      w_mem_we   = wea;
      w_mem_addr = addra;
      w_mem_din  = dina;
    end else begin
      w_mem_we = 1'b0;
    end
  end

  // State register and fill pointer; reset restarts the full fill sequence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= INIT;
      r_ptr   <= '0;
    end else if (r_state == INIT) begin
      r_state <= w_state_nxt;
      r_ptr   <= r_ptr + 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= r_ptr;
    end
  end

  // Storage array: one write port shared by the fill sequence and user writes.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  // Registered read data; a write returns old or new data depending on mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_douta <= '0;
    end else if (w_rd) begin
      r_douta <= w_rd_data;
    end else if (w_wr) begin
      r_douta <= WRITE_FIRST ? dina : w_rd_data;
    end else begin
      r_douta <= r_douta;
    end
  end

  // Sticky flag for accesses that arrived while the array was being filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc_drop <= 1'b0;
    end else if (w_drop) begin
      r_acc_drop <= 1'b1;
    end else begin
      r_acc_drop <= r_acc_drop;
    end
  end

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_wr_cnt (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (w_wr),
    .o_count (wr_count)
  );

  sat_counter #(.W(CNT_W), .MAX(CNT_MAX)) u_rd_cnt (
    .i_clk   (clk),
    .i_clr   (rst),
    .i_inc   (w_rd),
    .o_count (rd_count)
  );

  assign douta     = r_douta;
  assign init_busy = (r_state == INIT);
  assign acc_drop  = r_acc_drop;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder with a behavioural reference model.
module tb_mem_responder;

  localparam bit          WF   = 1'b0;
  localparam logic [15:0] IVAL = 16'h0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ena = 1'b0;
  logic        wea = 1'b0;
  logic [3:0]  addra = 4'd0;
  logic [15:0] dina = 16'h0000;
  logic [15:0] douta;
  logic        init_busy;
  logic        acc_drop;
  logic [7:0]  wr_count;
  logic [7:0]  rd_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [15:0] m_mem [16];
  logic [15:0] m_dout = 16'h0000;
  int          m_init_left = 16;
  int          m_wr = 0;
  int          m_rd = 0;
  bit          m_drop = 1'b0;

  mem_responder #(
    .DATA_W(16), .ADDR_W(4), .INIT_VAL(IVAL), .WRITE_FIRST(WF)
  ) dut (
    .clk(clk), .rst(rst), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .douta(douta), .init_busy(init_busy), .acc_drop(acc_drop),
    .wr_count(wr_count), .rd_count(rd_count)
  );

  always #5 clk = ~clk;

  wire [33:0] act_vec = {douta, init_busy, acc_drop, wr_count, rd_count};

  function automatic logic [33:0] exp_vec();
    logic [7:0] w8;
    logic [7:0] r8;
    w8 = m_wr[7:0];
    r8 = m_rd[7:0];
    return {m_dout, (m_init_left > 0), m_drop, w8, r8};
  endfunction

  // One clock edge of the reference behaviour.
  function automatic void model_step(input logic r, input logic e, input logic w,
                                     input logic [3:0] a, input logic [15:0] d);
    if (r) begin
      for (int i = 0; i < 16; i++) m_mem[i] = IVAL;
      m_init_left = 16;
      m_dout = 16'h0000;
      m_wr = 0;
      m_rd = 0;
      m_drop = 1'b0;
    end else if (m_init_left > 0) begin
      if (e) m_drop = 1'b1;
      m_init_left = m_init_left - 1;
    end else if (e) begin
      if (w) begin
        m_dout = WF ? d : m_mem[a];
        m_mem[a] = d;
        if (m_wr < 255) m_wr = m_wr + 1;
      end else begin
        m_dout = m_mem[a];
        if (m_rd < 255) m_rd = m_rd + 1;
      end
    end
  endfunction

  task automatic cyc(input logic r, input logic e, input logic w,
                     input logic [3:0] a, input logic [15:0] d);
    rst = r; ena = e; wea = w; addra = a; dina = d;
    @(posedge clk);
    model_step(r, e, w, a, d);
    #1;
  endtask

  task automatic reset_to_run();
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    repeat (16) cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
  endtask

  task automatic test_reset();
    cyc(1'b1, 1'b1, 1'b1, 4'd7, 16'hDEAD);
    total++;
    if (act_vec !== {16'h0000, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_state: got %h expected %h", act_vec,
               {16'h0000, 1'b1, 1'b0, 8'h00, 8'h00});
    end
  endtask

  task automatic test_init_idle();
    logic exp_busy;
    for (int k = 2; k <= 20; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
      exp_busy = (k <= 16);
      total++;
      if (init_busy !== exp_busy) begin
        bad++;
        $display("FAIL init_busy_cycle%0d: got %b expected %b", k, init_busy, exp_busy);
      end
    end
    for (int a = 0; a < 16; a++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'(a), 16'h0000);
      total++;
      if (douta !== 16'h0000) begin
        bad++;
        $display("FAIL init_read_addr%0d: got %h expected 0000", a, douta);
      end
    end
    total++;
    if (rd_count !== 8'd16 || wr_count !== 8'd0) begin
      bad++;
      $display("FAIL init_counts: got wr=%0d rd=%0d expected wr=0 rd=16", wr_count, rd_count);
    end
  endtask

  task automatic test_write_read();
    reset_to_run();
    cyc(1'b0, 1'b1, 1'b1, 4'd3, 16'hA5A5);
    cyc(1'b0, 1'b1, 1'b0, 4'd3, 16'h0000);
    total++;
    if (douta !== 16'hA5A5 || wr_count !== 8'd1 || rd_count !== 8'd1) begin
      bad++;
      $display("FAIL write_read: got d=%h wr=%0d rd=%0d expected d=a5a5 wr=1 rd=1",
               douta, wr_count, rd_count);
    end
  endtask

  task automatic test_write_collision();
    logic [15:0] exp_d;
    cyc(1'b0, 1'b1, 1'b1, 4'd5, 16'h1111);
    cyc(1'b0, 1'b1, 1'b1, 4'd5, 16'h2222);
    exp_d = WF ? 16'h2222 : 16'h1111;
    total++;
    if (douta !== exp_d) begin
      bad++;
      $display("FAIL write_mode_dout: got %h expected %h", douta, exp_d);
    end
    cyc(1'b0, 1'b1, 1'b0, 4'd5, 16'h0000);
    total++;
    if (douta !== 16'h2222) begin
      bad++;
      $display("FAIL read_after_write: got %h expected 2222", douta);
    end
  endtask

  task automatic test_drop();
    cyc(1'b1, 1'b0, 1'b0, 4'd0, 16'h0000);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b1, 4'd4, 16'hFFFF);
    total++;
    if (acc_drop !== 1'b1 || wr_count !== 8'd0 || douta !== 16'h0000) begin
      bad++;
      $display("FAIL drop_in_init: got drop=%b wr=%0d d=%h expected drop=1 wr=0 d=0000",
               acc_drop, wr_count, douta);
    end
    repeat (12) cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    total++;
    if (init_busy !== 1'b0 || acc_drop !== 1'b1) begin
      bad++;
      $display("FAIL drop_sticky: got busy=%b drop=%b expected busy=0 drop=1", init_busy, acc_drop);
    end
    cyc(1'b0, 1'b1, 1'b0, 4'd4, 16'h0000);
    total++;
    if (douta !== IVAL || wr_count !== 8'd0) begin
      bad++;
      $display("FAIL drop_no_write: got d=%h wr=%0d expected d=%h wr=0", douta, wr_count, IVAL);
    end
  endtask

  task automatic test_saturation();
    reset_to_run();
    for (int a = 0; a < 16; a++) cyc(1'b0, 1'b1, 1'b1, 4'(a), 16'($urandom));
    for (int i = 0; i < 300; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 4'($urandom_range(0, 15)), 16'($urandom));
      total++;
      if (act_vec !== exp_vec()) begin
        bad++;
        $display("FAIL sat_read%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
    total++;
    if (rd_count !== 8'hFF) begin
      bad++;
      $display("FAIL rd_saturate: got %h expected ff", rd_count);
    end
  endtask

  task automatic test_reset_run();
    reset_to_run();
    cyc(1'b0, 1'b1, 1'b1, 4'd15, 16'h00FF);
    cyc(1'b1, 1'b1, 1'b0, 4'd15, 16'h0000);
    total++;
    if (act_vec !== {16'h0000, 1'b1, 1'b0, 8'h00, 8'h00}) begin
      bad++;
      $display("FAIL reset_in_run: got %h expected %h", act_vec,
               {16'h0000, 1'b1, 1'b0, 8'h00, 8'h00});
    end
    repeat (16) cyc(1'b0, 1'b0, 1'b0, 4'd0, 16'h0000);
    cyc(1'b0, 1'b1, 1'b0, 4'd15, 16'h0000);
    total++;
    if (douta !== 16'h0000) begin
      bad++;
      $display("FAIL reset_clears_mem: got %h expected 0000", douta);
    end
  endtask

  task automatic test_random();
    logic r;
    reset_to_run();
    for (int i = 0; i < 400; i++) begin
      r = ($urandom_range(0, 49) == 0);
      cyc(r, ($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 16'($urandom));
      total++;
      if (act_vec !== exp_vec()) begin
        bad++;
        $display("FAIL random%0d: got %h expected %h", i, act_vec, exp_vec());
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) m_mem[i] = IVAL;
    test_reset();
    test_init_idle();
    test_write_read();
    test_write_collision();
    test_drop();
    test_saturation();
    test_reset_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
